framebuffer_scanout: RTL
========================

# framebuffer_scanout

Read-side scan-out engine for the 160x120, 1-bit dual-port framebuffer. It runs in the read (pixel) clock domain and generates 640x480@60 VGA timing. It drives the framebuffer's read port with addresses scaled 4x in both axes. It re-aligns the returned pixel data with delayed sync and blanking signals, so the VGA output pins see a coherent stream.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch (frame total 525)
- FB_WIDTH, 160, framebuffer columns (= H_ACTIVE >> SCALE_SHIFT)
- SCALE_SHIFT, 2, log2 of the upscale factor
- DATA_WIDTH, 1, framebuffer word width
- ADDR_WIDTH, 15, framebuffer address width

Ports:
- clock  in  1  pixel clock (25.175 MHz nominal); same clock as the framebuffer read_clock
- reset_n  in  1  asynchronous, active-low reset
- read_addr  out  ADDR_WIDTH  to framebuffer read_addr; registered
- q  in  DATA_WIDTH  from framebuffer q; valid one clock after read_addr
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while the output position is in the visible area
- pixel  out  DATA_WIDTH  pixel data; 0 whenever video_on is 0
- frame_start  out  1  one-cycle pulse when output position (0,0) is presented

## Operation
- **Counters:** h_count 0..799 increments every clock. When h_count wraps 799->0, v_count increments 0..524. v_count wraps 524->0 on the same edge that h_count wraps.
- **Active region:** h_count < H_ACTIVE and v_count < V_ACTIVE.
- **Sync windows:**
  - hsync asserted (0) when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync asserted (0) when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- **Address:** read_addr = (v_count>>2)*FB_WIDTH + (h_count>>2) in the active region, else 0.
  - Implement the multiply as (y<<7)+(y<<5); no multiplier.
  - Range 0..19199; never reaches 19200 or above.
- **Alignment:** video_on, hsync, vsync and frame_start are computed from the counters, then delayed through a 2-stage register pipeline. pixel = video_on ? q : 0, using the delayed video_on.
- **State machine:** none beyond the counters. The block free-runs, with no enable or handshake on the read port.

## Timing
- Cycle k = state after the k-th rising edge following reset_n deassertion.
- **Reset (asynchronous, immediate):**
  - h_count = 0, v_count = 0, read_addr = 0
  - hsync = 1, vsync = 1, video_on = 0, pixel = 0, frame_start = 0
  - all delay stages cleared to these values
- During reset the counters hold (0,0). Counting starts at k=1 (h_count = 1).
- **Latency:** counter position at cycle n drives read_addr at n+1, so q arrives at n+2. All outputs at n+2 reflect position n; total latency is 2 cycles.
- **First frame after reset:** first frame_start at k=2, with video_on = 1 on the same cycle.
- **Periods:**
  - frame_start every 420000 cycles
  - hsync falling edges every 800 cycles; each low for 96 cycles
  - vsync low for 1600 cycles per frame
- **Relative to frame_start (cycle 0):**
  - first hsync falls at cycle 656
  - video_on falls at cycle 640 and rises again at cycle 800
  - vsync falls at cycle 490*800 = 392000
- **Reset mid-frame:** all outputs return to reset values asynchronously. No partial line is emitted after release; the timeline restarts exactly as at power-up.

## Test plan
- **Reset behaviour:**
  - Stimulus: assert reset_n = 0 at v_count = 200, h_count = 300, between clock edges.
  - Required response: outputs immediately hsync = 1, vsync = 1, video_on = 0, pixel = 0, read_addr = 0.
  - After release, frame_start at k=2.
- **Horizontal timing:**
  - Stimulus: run from frame_start.
  - Required response: hsync low for exactly cycles 656..751 of every line; video_on high for cycles 0..639 of each line; line period 800.
- **Vertical timing:**
  - Stimulus: run two frames.
  - Required response: vsync low for cycles 392000..393599 after frame_start; frame_start spacing exactly 420000; no video_on during lines 480..524.
- **Address generation:**
  - Stimulus: check read_addr one cycle after counter positions (0,0), (3,3), (4,4), (639,479) and (640,0).
  - Required response: 0, 0, 161, 19199, 0 respectively.
- **Pixel alignment:**
  - Stimulus: attach a registered-read RAM model with mem[161] = 1 and all other locations 0.
  - Required response: pixel = 1 for exactly 16 outputs per frame, at output positions h 4..7, v 4..7; pixel = 0 elsewhere and during blanking.
- **Full-screen pattern:**
  - Stimulus: fill the RAM with 0 inside columns 40..119, rows 30..89, and 1 elsewhere.
  - Required response: pixel = 0 exactly for output h 160..479, v 120..359; all other visible pixels = 1.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// VGA scan-out for a 1-bit framebuffer upscaled by 2**SCALE_SHIFT on both axes.
// Timing strobes are delayed two clocks so they line up with the registered-read pixel data.
module framebuffer_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int FB_WIDTH    = 160,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_on,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_CW    = $clog2(H_TOTAL);
  localparam int V_CW    = $clog2(V_TOTAL);

  localparam logic [H_CW-1:0] H_LAST       = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_VISIBLE    = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] H_SYNC_START = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] H_SYNC_END   = H_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST       = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_VISIBLE    = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] V_SYNC_START = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] V_SYNC_END   = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
    logic frame_start;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1, frame_start: 1'b0};

  logic [H_CW-1:0]       h_count;
  logic [V_CW-1:0]       v_count;
  logic                  active;
  logic [H_CW-1:0]       fb_x;
  logic [V_CW-1:0]       fb_y;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] addr_next;
  strobes_t              strobes_now;
  strobes_t              strobes_d1;
  strobes_t              strobes_d2;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  always_comb begin
    active                  = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
    strobes_now.video_on    = active;
    strobes_now.hsync       = !((h_count >= H_SYNC_START) && (h_count < H_SYNC_END));
    strobes_now.vsync       = !((v_count >= V_SYNC_START) && (v_count < V_SYNC_END));
    strobes_now.frame_start = (h_count == '0) && (v_count == '0);

    fb_x = h_count >> SCALE_SHIFT;
    fb_y = v_count >> SCALE_SHIFT;

    // NOTE: row_base gets its default before the loop so no path leaves it unassigned (no latch).
    // Row base is fb_y * FB_WIDTH as a sum of shifted copies, one per set bit of FB_WIDTH.
    row_base = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (((FB_WIDTH >> i) & 1) != 0) begin
        row_base = row_base + (ADDR_WIDTH'(fb_y) << i);
      end
    end
    addr_next = active ? row_base + ADDR_WIDTH'(fb_x) : '0;
  end

  // Two strobe stages: one for the address register, one for the RAM's registered read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_addr  <= '0;
      strobes_d1 <= STROBES_IDLE;
      strobes_d2 <= STROBES_IDLE;
    end else begin
      read_addr  <= addr_next;
      strobes_d1 <= strobes_now;
      strobes_d2 <= strobes_d1;
    end
  end

  assign video_on    = strobes_d2.video_on;
  assign hsync       = strobes_d2.hsync;
  assign vsync       = strobes_d2.vsync;
  assign frame_start = strobes_d2.frame_start;
  assign pixel       = strobes_d2.video_on ? q : '0;

endmodule
